// File: rtl/blake2s_msg_feeder.sv
// -----------------------------------------------------------------------------
// blake2s_msg_feeder
//
// Upstream transmitter for a BLAKE2s hash core (unkeyed hashing only).
// The feeder takes a message as a byte stream with a valid/ready handshake and
// collects it into 64-byte blocks. It zero-pads the final block and presents
// each block to the core one byte per cycle. It then waits for the core's
// per-block acknowledge. After the last block it also waits for final
// completion, and only then accepts the next message.
//
// Ports
//   clk, reset      : clock; synchronous active-high reset
//   msg_v_i         : upstream byte valid
//   msg_ready_o     : feeder accepts a byte this cycle
//   msg_i           : message byte
//   msg_last_i      : marks the final byte of the message (with msg_v_i)
//   kk_o            : key length to core (always 0, unkeyed)
//   nn_o            : digest length to core (constant NN)
//   ll_o            : byte count through the end of the current block
//   block_first_o   : current block is the first of the message
//   block_last_o    : current block is the last of the message
//   data_v_o        : byte strobe to core
//   data_idx_o      : byte index within block
//   data_o          : block byte (zero beyond the filled length)
//   blk_ack_i       : core pulse, block consumed
//   finished_i      : core pulse, final hash complete
//   done_o          : one-cycle pulse, message fully hashed
// -----------------------------------------------------------------------------
module blake2s_msg_feeder #(
  parameter int NN = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        msg_v_i,
  output logic        msg_ready_o,
  input  logic [7:0]  msg_i,
  input  logic        msg_last_i,
  output logic [5:0]  kk_o,
  output logic [5:0]  nn_o,
  output logic [63:0] ll_o,
  output logic        block_first_o,
  output logic        block_last_o,
  output logic        data_v_o,
  output logic [5:0]  data_idx_o,
  output logic [7:0]  data_o,
  input  logic        blk_ack_i,
  input  logic        finished_i,
  output logic        done_o
);

  // Block size is fixed by the BLAKE2s algorithm, so it is not a parameter.
  localparam int BB = 64;

  typedef enum logic [2:0] {
    S_FILL,
    S_SEND,
    S_WAIT_ACK,
    S_WAIT_FIN,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;      // bytes held in the buffer, 0..64
  logic [63:0] tot_q, tot_d;      // message bytes accepted so far
  logic        first_q, first_d;
  logic        last_q, last_d;
  logic [5:0]  idx_q, idx_d;      // byte index during SEND

  logic [7:0]  blk_buf_q [BB];
  logic        wr_en;

  assign kk_o = '0;
  assign nn_o = 6'(NN);

  // Next-state logic and control outputs.
  always_comb begin
    // NOTE: every signal gets a default here, so no path through the case can
    // leave it unassigned. An unassigned path would infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    tot_d       = tot_q;
    first_d     = first_q;
    last_d      = last_q;
    idx_d       = idx_q;
    wr_en       = 1'b0;
    msg_ready_o = 1'b0;
    data_v_o    = 1'b0;
    done_o      = 1'b0;

    unique case (state_q)
      S_FILL: begin
        msg_ready_o = 1'b1;
        if (msg_v_i) begin
          wr_en = 1'b1;
          cnt_d = cnt_q + 7'd1;
          tot_d = tot_q + 64'd1;
          // A last byte ends the block at any fill level, including the 64th byte.
          if (msg_last_i) begin
            last_d  = 1'b1;
            idx_d   = '0;
            state_d = S_SEND;
          end else if (cnt_q == 7'(BB - 1)) begin
            last_d  = 1'b0;
            idx_d   = '0;
            state_d = S_SEND;
          end
        end
      end

      S_SEND: begin
        data_v_o = 1'b1;
        idx_d    = idx_q + 6'd1;
        if (idx_q == 6'(BB - 1)) begin
          state_d = S_WAIT_ACK;
        end
      end

      S_WAIT_ACK: begin
        // If finished_i arrives in the same cycle as the ack, it is dropped;
        // only the ack counts here.
        if (blk_ack_i) begin
          cnt_d   = '0;
          first_d = 1'b0;
          state_d = last_q ? S_WAIT_FIN : S_FILL;
        end
      end

      S_WAIT_FIN: begin
        if (finished_i) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        done_o  = 1'b1;
        cnt_d   = '0;
        tot_d   = '0;
        first_d = 1'b1;
        last_d  = 1'b0;
        state_d = S_FILL;
      end

      default: begin
        state_d = S_FILL;
      end
    endcase
  end

  // Block-side data path. Bytes past the filled length read as zero padding.
  always_comb begin
    data_idx_o    = '0;
    data_o        = '0;
    block_first_o = 1'b0;
    block_last_o  = 1'b0;
    if (state_q == S_SEND) begin
      data_idx_o    = idx_q;
      block_first_o = first_q;
      block_last_o  = last_q;
      if ({1'b0, idx_q} < cnt_q) begin
        data_o = blk_buf_q[idx_q];
      end
    end
  end

  // tot holds still outside FILL, so ll_o is stable through SEND and WAIT_ACK.
  // Reset and DONE clear tot, so ll_o also reads 0 at those points.
  assign ll_o = tot_q;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples values from before the clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FILL;
      cnt_q   <= '0;
      tot_q   <= '0;
      first_q <= 1'b1;
      last_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tot_q   <= tot_d;
      first_q <= first_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
    end
  end

  // NOTE: the byte buffer is deliberately not reset. Only entries below cnt are
  // ever read, and cnt is reset, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      blk_buf_q[cnt_q[5:0]] <= msg_i;
    end
  end

endmodule

// File: tb/tb_blake2s_msg_feeder.sv
// -----------------------------------------------------------------------------
// tb_blake2s_msg_feeder
//
// Directed bench for blake2s_msg_feeder. Inputs are driven and outputs are
// sampled on the falling edge of clk; the design acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_blake2s_msg_feeder;

  logic        clk;
  logic        reset;
  logic        msg_v_i;
  logic        msg_ready_o;
  logic [7:0]  msg_i;
  logic        msg_last_i;
  logic [5:0]  kk_o;
  logic [5:0]  nn_o;
  logic [63:0] ll_o;
  logic        block_first_o;
  logic        block_last_o;
  logic        data_v_o;
  logic [5:0]  data_idx_o;
  logic [7:0]  data_o;
  logic        blk_ack_i;
  logic        finished_i;
  logic        done_o;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_blk [64];

  blake2s_msg_feeder #(.NN(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .msg_v_i      (msg_v_i),
    .msg_ready_o  (msg_ready_o),
    .msg_i        (msg_i),
    .msg_last_i   (msg_last_i),
    .kk_o         (kk_o),
    .nn_o         (nn_o),
    .ll_o         (ll_o),
    .block_first_o(block_first_o),
    .block_last_o (block_last_o),
    .data_v_o     (data_v_o),
    .data_idx_o   (data_idx_o),
    .data_o       (data_o),
    .blk_ack_i    (blk_ack_i),
    .finished_i   (finished_i),
    .done_o       (done_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 64; i++) exp_blk[i] = 8'h00;
  endtask

  // Called on a falling edge. Returns on the falling edge after the transfer.
  task automatic send_byte(input logic [7:0] b, input logic last);
    int w = 0;
    msg_v_i    = 1'b1;
    msg_i      = b;
    msg_last_i = last;
    while (!msg_ready_o && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) check("send_byte timeout", 64'(w), 64'd0);
    @(negedge clk);
    msg_v_i    = 1'b0;
    msg_last_i = 1'b0;
  endtask

  // Checks one full 64-cycle SEND burst against exp_blk and the given flags.
  // Data must be valid at the very first falling edge after the block-completing transfer.
  task automatic capture_block(input string tag, input logic ef, input logic el,
                               input logic [63:0] ell);
    check({tag, " data_v at start"}, 64'(data_v_o), 64'd1);
    for (int i = 0; i < 64; i++) begin
      if (!data_v_o) break;
      check($sformatf("%s idx%0d index", tag, i), 64'(data_idx_o), 64'(i));
      check($sformatf("%s idx%0d data", tag, i), 64'(data_o), 64'(exp_blk[i]));
      check($sformatf("%s idx%0d ready", tag, i), 64'(msg_ready_o), 64'd0);
      if (i == 0 || i == 63) begin
        check($sformatf("%s idx%0d first", tag, i), 64'(block_first_o), 64'(ef));
        check($sformatf("%s idx%0d last", tag, i), 64'(block_last_o), 64'(el));
        check($sformatf("%s idx%0d ll", tag, i), ll_o, ell);
      end
      @(negedge clk);
    end
    check({tag, " data_v after burst"}, 64'(data_v_o), 64'd0);
    check({tag, " ll held in WAIT_ACK"}, ll_o, ell);
  endtask

  task automatic ack_pulse();
    blk_ack_i = 1'b1;
    @(negedge clk);
    blk_ack_i = 1'b0;
  endtask

  // Ack the final block, finish the hash, and confirm the one-cycle done pulse.
  task automatic finish_msg(input string tag);
    ack_pulse();
    check({tag, " done before finish"}, 64'(done_o), 64'd0);
    check({tag, " ready in WAIT_FIN"}, 64'(msg_ready_o), 64'd0);
    finished_i = 1'b1;
    @(negedge clk);
    finished_i = 1'b0;
    check({tag, " done pulse"}, 64'(done_o), 64'd1);
    check({tag, " ready during DONE"}, 64'(msg_ready_o), 64'd0);
    @(negedge clk);
    check({tag, " done cleared"}, 64'(done_o), 64'd0);
    check({tag, " ready after DONE"}, 64'(msg_ready_o), 64'd1);
    check({tag, " ll cleared"}, ll_o, 64'd0);
  endtask

  initial begin
    reset      = 1'b1;
    msg_v_i    = 1'b0;
    msg_i      = 8'h00;
    msg_last_i = 1'b0;
    blk_ack_i  = 1'b0;
    finished_i = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst ready", 64'(msg_ready_o), 64'd1);
    check("rst data_v", 64'(data_v_o), 64'd0);
    check("rst idx", 64'(data_idx_o), 64'd0);
    check("rst data", 64'(data_o), 64'd0);
    check("rst first", 64'(block_first_o), 64'd0);
    check("rst last", 64'(block_last_o), 64'd0);
    check("rst ll", ll_o, 64'd0);
    check("rst done", 64'(done_o), 64'd0);
    check("kk", 64'(kk_o), 64'd0);
    check("nn", 64'(nn_o), 64'd32);
    reset = 1'b0;
    @(negedge clk);

    // "abc": one padded block.
    send_byte(8'h61, 1'b0);
    send_byte(8'h62, 1'b0);
    send_byte(8'h63, 1'b1);
    clear_exp();
    exp_blk[0] = 8'h61; exp_blk[1] = 8'h62; exp_blk[2] = 8'h63;
    capture_block("abc", 1'b1, 1'b1, 64'd3);
    finish_msg("abc");

    // 64 bytes: exactly one full block, no padding.
    for (int i = 0; i < 64; i++) send_byte(8'(i), i == 63);
    for (int i = 0; i < 64; i++) exp_blk[i] = 8'(i);
    capture_block("m64", 1'b1, 1'b1, 64'd64);
    finish_msg("m64");

    // 65 bytes: full block, then a one-byte tail block.
    for (int i = 0; i < 64; i++) send_byte(8'(i), 1'b0);
    capture_block("m65 b1", 1'b1, 1'b0, 64'd64);
    ack_pulse();
    check("m65 ready after ack", 64'(msg_ready_o), 64'd1);
    send_byte(8'h40, 1'b1);
    clear_exp();
    exp_blk[0] = 8'h40;
    capture_block("m65 b2", 1'b0, 1'b1, 64'd65);
    finish_msg("m65");

    // Backpressure: AA held valid through SEND and WAIT_ACK.
    for (int i = 0; i < 64; i++) send_byte(8'(i * 3), 1'b0);
    msg_v_i    = 1'b1;
    msg_i      = 8'hAA;
    msg_last_i = 1'b1;
    for (int i = 0; i < 64; i++) exp_blk[i] = 8'(i * 3);
    capture_block("bp b1", 1'b1, 1'b0, 64'd64);
    check("bp ready WAIT_ACK 0", 64'(msg_ready_o), 64'd0);
    @(negedge clk);
    check("bp ready WAIT_ACK 1", 64'(msg_ready_o), 64'd0);
    ack_pulse();
    check("bp ready in FILL", 64'(msg_ready_o), 64'd1);
    @(negedge clk);
    msg_v_i    = 1'b0;
    msg_last_i = 1'b0;
    clear_exp();
    exp_blk[0] = 8'hAA;
    capture_block("bp b2", 1'b0, 1'b1, 64'd65);
    finish_msg("bp");

    // Reset in the middle of SEND at index 20.
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b1);
    repeat (20) @(negedge clk);
    check("mid idx before reset", 64'(data_idx_o), 64'd20);
    reset = 1'b1;
    @(negedge clk);
    check("mid data_v", 64'(data_v_o), 64'd0);
    check("mid ready", 64'(msg_ready_o), 64'd1);
    check("mid ll", ll_o, 64'd0);
    check("mid done", 64'(done_o), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    send_byte(8'h5A, 1'b1);
    clear_exp();
    exp_blk[0] = 8'h5A;
    capture_block("post rst", 1'b1, 1'b1, 64'd1);
    finish_msg("post rst");

    // Spurious ack and finish pulses.
    blk_ack_i  = 1'b1;
    finished_i = 1'b1;
    @(negedge clk);
    blk_ack_i  = 1'b0;
    finished_i = 1'b0;
    check("spur FILL ready", 64'(msg_ready_o), 64'd1);
    check("spur FILL done", 64'(done_o), 64'd0);
    check("spur FILL data_v", 64'(data_v_o), 64'd0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b1);
    clear_exp();
    exp_blk[0] = 8'h01; exp_blk[1] = 8'h02; exp_blk[2] = 8'h03;
    fork
      capture_block("spur", 1'b1, 1'b1, 64'd3);
      begin
        repeat (5) @(negedge clk);
        blk_ack_i = 1'b1;
        @(negedge clk);
        blk_ack_i = 1'b0;
      end
    join
    finished_i = 1'b1;
    @(negedge clk);
    finished_i = 1'b0;
    check("spur fin in WAIT_ACK done", 64'(done_o), 64'd0);
    check("spur fin in WAIT_ACK ready", 64'(msg_ready_o), 64'd0);
    check("spur fin in WAIT_ACK ll", ll_o, 64'd3);
    // Ack and finish together: only the ack is taken.
    blk_ack_i  = 1'b1;
    finished_i = 1'b1;
    @(negedge clk);
    blk_ack_i  = 1'b0;
    finished_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("both pulse done %0d", i), 64'(done_o), 64'd0);
      check($sformatf("both pulse ready %0d", i), 64'(msg_ready_o), 64'd0);
      @(negedge clk);
    end
    finished_i = 1'b1;
    @(negedge clk);
    finished_i = 1'b0;
    check("spur done pulse", 64'(done_o), 64'd1);
    @(negedge clk);
    check("spur done cleared", 64'(done_o), 64'd0);
    check("spur ready after", 64'(msg_ready_o), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/blake2s_msg_feeder.md
Name: blake2s_msg_feeder

Overview:
Upstream transmitter for the BLAKE2s hash core. It accepts an arbitrary-length message as a byte stream with a valid/ready handshake and buffers it into 64-byte blocks. It zero-pads the final block and drives the core's byte-serial block interface: data_v/data_idx/data, block_first/block_last, kk/nn/ll. It then waits for the core's per-block acknowledge and final completion before accepting the next message. Unkeyed hashing only.

Parameters:
NN, 32, digest length in bytes, driven constant on nn_o (1..32)
BB, 64, block size in bytes; fixed for BLAKE2s, not to be overridden

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
msg_v_i  in  1  upstream byte valid
msg_ready_o  out  1  feeder accepts byte this cycle
msg_i  in  8  message byte
msg_last_i  in  1  qualifies final byte of message (valid only with msg_v_i)
kk_o  out  6  key length to core; constant 0
nn_o  out  6  digest length to core; constant NN
ll_o  out  64  byte count through end of current block
block_first_o  out  1  current block is first of message
block_last_o  out  1  current block is last of message
data_v_o  out  1  byte strobe to core
data_idx_o  out  6  byte index within block
data_o  out  8  block byte
blk_ack_i  in  1  core pulse: block consumed, compression done
finished_i  in  1  core pulse: final hash complete
done_o  out  1  one-cycle pulse: message fully hashed

Behaviour:
- Storage: 64x8 buffer; fill counter cnt[6:0] (0..64); total counter tot[63:0]; first flag; last flag.
- States: FILL, SEND, WAIT_ACK, WAIT_FIN, DONE.
- Reset (any state, mid-operation included): state=FILL, cnt=0, tot=0, first=1, last=0; outputs msg_ready_o=1, data_v_o=0, data_idx_o=0, data_o=0, block_first_o=0, block_last_o=0, ll_o=0, done_o=0. kk_o=0, nn_o=NN at all times.
- FILL: msg_ready_o=1. A byte transfers on msg_v_i&msg_ready_o; it is written to buf[cnt], cnt++, tot++.
  - Transfer with msg_last_i=1: set last, go to SEND. This applies at any cnt, including the 64th byte.
  - Transfer of the 64th byte with msg_last_i=0: go to SEND, last=0.
- SEND: msg_ready_o=0. It lasts exactly 64 cycles, starting the cycle after the final FILL transfer.
  - data_v_o=1 and data_idx_o steps 0..63, one per cycle.
  - data_o = buf[idx] if idx<cnt, else 8'h00 (zero padding).
  - block_first_o=first and block_last_o=last, held for all 64 cycles.
  - ll_o=tot, stable through SEND and WAIT_ACK.
  - After idx 63, go to WAIT_ACK; data_v_o=0.
- WAIT_ACK: on blk_ack_i, set cnt=0 and first=0.
  - If last: go to WAIT_FIN.
  - Else: go to FILL.
- WAIT_FIN: on finished_i, go to DONE.
- DONE: done_o=1 for exactly one cycle. Then cnt=0, tot=0, first=1, last=0; go to FILL.
- blk_ack_i outside WAIT_ACK and finished_i outside WAIT_FIN are ignored. Both asserted together in WAIT_ACK: only the ack is taken.
- Message byte latency: from FILL transfer to appearance on data_o is ≥1 cycle. The block's first data_v_o comes 1 cycle after the block-completing transfer.
- Empty messages (ll=0) are unsupported; upstream always sends ≥1 byte. tot wraps mod 2^64 (unreachable in practice).
- msg_last_i without msg_v_i is ignored.

Test Plan:
- "abc" (61,62,63, last on 63) -> one SEND: idx0..2=61,62,63, idx3..63=00; first=last=1; ll_o=3. After blk_ack_i then finished_i: done_o pulses 1 cycle; msg_ready_o=1 the cycle after.
- 64 bytes 00..3F, last on 3F -> single block: first=last=1, ll_o=64, data_o=idx at every index, no padding.
- 65 bytes (00..40) -> block 1: first=1, last=0, ll_o=64. After ack, FILL takes byte 40. Block 2: first=0, last=1, ll_o=65, idx0=40, idx1..63=00.
- Backpressure: msg_v_i held high with byte AA through SEND/WAIT_ACK -> msg_ready_o=0 throughout. AA is accepted on the first FILL cycle and appears exactly once at idx0 of the next block.
- Reset asserted during SEND at idx 20 -> next cycle data_v_o=0, msg_ready_o=1, ll_o=0. The following message's first block has block_first_o=1 and tot restarts from 0.
- Spurious blk_ack_i in FILL and SEND, and finished_i in WAIT_ACK -> no state change, done_o stays 0; the later legal ack/finish proceed normally.
